// File: rtl/ev_counter_bank.sv
// Multi-channel event counter: per-channel synchroniser, selectable edge detect,
// wrap/saturate counting with sticky overflow, and an all-channel atomic snapshot.
module ev_counter_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SATURATE    = 0,
  localparam int unsigned SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] ev_i,
  input  logic [CHANNELS-1:0] en_i,
  input  logic [1:0]          mode_i,
  input  logic [CHANNELS-1:0] clr_i,
  input  logic                snap_i,
  input  logic [SEL_W-1:0]    sel_i,
  output logic [WIDTH-1:0]    cnt_o,
  output logic [WIDTH-1:0]    snap_o,
  output logic [CHANNELS-1:0] ovf_o,
  output logic                any_ovf_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q   [CHANNELS];
  logic [WIDTH-1:0]       cnt_q    [CHANNELS];
  logic [WIDTH-1:0]       shadow_q [CHANNELS];
  logic [CHANNELS-1:0]    prev_q;
  logic [CHANNELS-1:0]    ovf_q;
  logic [CHANNELS-1:0]    s_last;
  logic [CHANNELS-1:0]    rise;
  logic [CHANNELS-1:0]    fall;
  logic [CHANNELS-1:0]    hit;

  // Synchroniser chains and the previous-value flop behind them
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        sync_q[c] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], ev_i[c]};
      end
      prev_q <= s_last;
    end
  end

  always_comb begin
    s_last = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      s_last[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

  assign rise = s_last & ~prev_q;
  assign fall = ~s_last & prev_q;

  // Global edge mode selects which transitions count
  always_comb begin
    hit = '0;
    case (mode_i)
      2'b01:   hit = rise;
      2'b10:   hit = fall;
      2'b11:   hit = rise | fall;
      default: hit = '0;
    endcase
  end

  // Counters, sticky overflow and shadows; clear beats a same-cycle hit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        cnt_q[c]    <= '0;
        shadow_q[c] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (snap_i) begin
          shadow_q[c] <= cnt_q[c];
        end
        if (clr_i[c]) begin
          cnt_q[c] <= '0;
          ovf_q[c] <= 1'b0;
        end else if (hit[c] && en_i[c]) begin
          if (cnt_q[c] == CNT_MAX) begin
            ovf_q[c] <= 1'b1;
            if (SATURATE == 0) begin
              cnt_q[c] <= '0;
            end
          end else begin
            cnt_q[c] <= cnt_q[c] + WIDTH'(1);
          end
        end
      end
    end
  end

  // Read mux; out-of-range selects read as zero
  always_comb begin
    cnt_o  = '0;
    snap_o = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (sel_i == SEL_W'(c)) begin
        cnt_o  = cnt_q[c];
        snap_o = shadow_q[c];
      end
    end
  end

  assign ovf_o     = ovf_q;
  assign any_ovf_o = |ovf_q;

endmodule

// File: tb/tb_ev_counter_bank.sv
// Directed bench for ev_counter_bank: wrapping, saturating and 3-channel instances
// share stimulus; each task checks one behaviour against hand-computed values.
module tb_ev_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ev;
  logic [3:0] en;
  logic [1:0] mode;
  logic [3:0] clr;
  logic       snap;
  logic [1:0] sel;
  logic [1:0] sel3;

  logic [7:0] cnt, snp, cnt_s, snp_s, cnt3, snp3;
  logic [3:0] ovf, ovf_s;
  logic [2:0] ovf3;
  logic       any_ovf, any_ovf_s, any_ovf3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ev_counter_bank #(.CHANNELS(4), .WIDTH(8), .SYNC_STAGES(2), .SATURATE(0)) dut (
    .clk_i(clk), .rst_i(rst), .ev_i(ev), .en_i(en), .mode_i(mode), .clr_i(clr),
    .snap_i(snap), .sel_i(sel), .cnt_o(cnt), .snap_o(snp), .ovf_o(ovf), .any_ovf_o(any_ovf)
  );

  ev_counter_bank #(.CHANNELS(4), .WIDTH(8), .SYNC_STAGES(2), .SATURATE(1)) dut_sat (
    .clk_i(clk), .rst_i(rst), .ev_i(ev), .en_i(en), .mode_i(mode), .clr_i(clr),
    .snap_i(snap), .sel_i(sel), .cnt_o(cnt_s), .snap_o(snp_s), .ovf_o(ovf_s),
    .any_ovf_o(any_ovf_s)
  );

  ev_counter_bank #(.CHANNELS(3), .WIDTH(8), .SYNC_STAGES(2), .SATURATE(0)) dut3 (
    .clk_i(clk), .rst_i(rst), .ev_i(ev[2:0]), .en_i(en[2:0]), .mode_i(mode),
    .clr_i(clr[2:0]), .snap_i(snap), .sel_i(sel3), .cnt_o(cnt3), .snap_o(snp3),
    .ovf_o(ovf3), .any_ovf_o(any_ovf3)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tog(input logic [3:0] m);
    ev = ev ^ m;
    tick(2);
  endtask

  task automatic pulse(input int ch);
    ev[ch] = 1'b1;
    tick(2);
    ev[ch] = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    rst = 1'b0; ev = '0; en = 4'hF; mode = 2'b01; clr = '0; snap = 1'b0;
    sel = 2'd0; sel3 = 2'd0;
    tick(3);
    rst = 1'b1;
    tick(1);
    pulse(0);
    tick(3);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    n_cmp++;
    if (cnt !== 8'd1) begin n_err++; $display("FAIL pre_reset_cnt got %0d want 1", cnt); end
    n_cmp++;
    if (snp !== 8'd1) begin n_err++; $display("FAIL pre_reset_snap got %0d want 1", snp); end
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    n_cmp++;
    if (snp !== 8'd0) begin n_err++; $display("FAIL reset_snap got %0d want 0", snp); end
    n_cmp++;
    if (ovf !== 4'd0) begin n_err++; $display("FAIL reset_ovf got %b want 0000", ovf); end
    n_cmp++;
    if (any_ovf !== 1'b0) begin n_err++; $display("FAIL reset_any_ovf got %b want 0", any_ovf); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_latency;
    sel = 2'd2;
    ev[2] = 1'b1;
    tick(2);
    n_cmp++;
    if (cnt !== 8'd0) begin n_err++; $display("FAIL latency_edge2 got %0d want 0", cnt); end
    tick(1);
    n_cmp++;
    if (cnt !== 8'd1) begin n_err++; $display("FAIL latency_edge3 got %0d want 1", cnt); end
    ev[2] = 1'b0;
    tick(4);
  endtask

  task automatic test_modes;
    logic [1:0] md;
    logic [7:0] ex;
    sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin md = 2'b01; ex = 8'd5;  end
        1:       begin md = 2'b10; ex = 8'd5;  end
        2:       begin md = 2'b11; ex = 8'd10; end
        default: begin md = 2'b00; ex = 8'd0;  end
      endcase
      clr = 4'b0001;
      tick(1);
      clr = '0;
      mode = md;
      repeat (5) pulse(0);
      tick(3);
      n_cmp++;
      if (cnt !== ex) begin n_err++; $display("FAIL mode_%b got %0d want %0d", md, cnt, ex); end
    end
  endtask

  task automatic test_enable;
    sel = 2'd0;
    mode = 2'b01;
    clr = 4'b0001;
    tick(1);
    clr = '0;
    for (int p = 0; p < 5; p++) begin
      en[0] = !(p >= 1 && p <= 3);
      pulse(0);
    end
    en[0] = 1'b1;
    tick(3);
    n_cmp++;
    if (cnt !== 8'd2) begin n_err++; $display("FAIL enable_gate got %0d want 2", cnt); end
  endtask

  task automatic test_wrap;
    sel = 2'd0;
    mode = 2'b11;
    clr = 4'b0001;
    tick(1);
    clr = '0;
    repeat (255) tog(4'b0001);
    tick(3);
    n_cmp++;
    if (cnt !== 8'd255) begin n_err++; $display("FAIL wrap_preload got %0d want 255", cnt); end
    n_cmp++;
    if (ovf[0] !== 1'b0) begin n_err++; $display("FAIL wrap_preload_ovf got %b want 0", ovf[0]); end
    tog(4'b0001);
    tick(3);
    n_cmp++;
    if (cnt !== 8'd0) begin n_err++; $display("FAIL wrap_cnt got %0d want 0", cnt); end
    n_cmp++;
    if (ovf[0] !== 1'b1) begin n_err++; $display("FAIL wrap_ovf got %b want 1", ovf[0]); end
    n_cmp++;
    if (any_ovf !== 1'b1) begin n_err++; $display("FAIL wrap_any_ovf got %b want 1", any_ovf); end
    n_cmp++;
    if (cnt_s !== 8'd255) begin n_err++; $display("FAIL sat_cnt got %0d want 255", cnt_s); end
    n_cmp++;
    if (ovf_s[0] !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", ovf_s[0]); end
  endtask

  task automatic test_clear_priority;
    sel = 2'd1;
    mode = 2'b11;
    clr = 4'b0010;
    tick(1);
    clr = '0;
    repeat (263) tog(4'b0010);
    tick(3);
    n_cmp++;
    if (cnt !== 8'd7) begin n_err++; $display("FAIL clr_pre_cnt got %0d want 7", cnt); end
    n_cmp++;
    if (ovf[1] !== 1'b1) begin n_err++; $display("FAIL clr_pre_ovf got %b want 1", ovf[1]); end
    ev[1] = ~ev[1];
    tick(2);
    clr = 4'b0010;
    tick(1);
    clr = '0;
    n_cmp++;
    if (cnt !== 8'd0) begin n_err++; $display("FAIL clr_cnt got %0d want 0", cnt); end
    n_cmp++;
    if (ovf[1] !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b want 0", ovf[1]); end
    tick(3);
    n_cmp++;
    if (cnt !== 8'd0) begin n_err++; $display("FAIL clr_event_dropped got %0d want 0", cnt); end
    sel = 2'd0;
    #1;
    n_cmp++;
    if (cnt !== 8'd0) begin n_err++; $display("FAIL clr_other_cnt got %0d want 0", cnt); end
    n_cmp++;
    if (ovf !== 4'b0001) begin n_err++; $display("FAIL clr_other_ovf got %b want 0001", ovf); end
  endtask

  task automatic test_snapshot;
    logic [7:0] ex;
    mode = 2'b11;
    clr = 4'hF;
    tick(1);
    clr = '0;
    for (int i = 0; i < 12; i++) begin
      tog({1'b1, 1'b0, (i < 9) ? 1'b1 : 1'b0, (i < 3) ? 1'b1 : 1'b0});
    end
    tick(3);
    ev[0] = ~ev[0];
    tick(2);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       ex = 8'd3;
        1:       ex = 8'd9;
        2:       ex = 8'd0;
        default: ex = 8'd12;
      endcase
      sel = 2'(s);
      #1;
      n_cmp++;
      if (snp !== ex) begin n_err++; $display("FAIL snap_sel%0d got %0d want %0d", s, snp, ex); end
    end
    sel = 2'd0;
    #1;
    n_cmp++;
    if (cnt !== 8'd4) begin n_err++; $display("FAIL snap_live0 got %0d want 4", cnt); end
    clr = 4'hF;
    tick(1);
    clr = '0;
    n_cmp++;
    if (cnt !== 8'd0) begin n_err++; $display("FAIL snap_clr_live got %0d want 0", cnt); end
    n_cmp++;
    if (snp !== 8'd3) begin n_err++; $display("FAIL snap_kept0 got %0d want 3", snp); end
    sel = 2'd3;
    #1;
    n_cmp++;
    if (snp !== 8'd12) begin n_err++; $display("FAIL snap_kept3 got %0d want 12", snp); end
  endtask

  task automatic test_select;
    mode = 2'b11;
    clr = 4'hF;
    tick(1);
    clr = '0;
    repeat (5) tog(4'b0111);
    tick(3);
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    sel3 = 2'd2;
    #1;
    n_cmp++;
    if (cnt3 !== 8'd5) begin n_err++; $display("FAIL sel3_ch2_cnt got %0d want 5", cnt3); end
    n_cmp++;
    if (snp3 !== 8'd5) begin n_err++; $display("FAIL sel3_ch2_snap got %0d want 5", snp3); end
    sel3 = 2'd3;
    #1;
    n_cmp++;
    if (cnt3 !== 8'd0) begin n_err++; $display("FAIL sel3_oob_cnt got %0d want 0", cnt3); end
    n_cmp++;
    if (snp3 !== 8'd0) begin n_err++; $display("FAIL sel3_oob_snap got %0d want 0", snp3); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_enable();
    test_wrap();
    test_clear_priority();
    test_snapshot();
    test_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
